// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed, double-buffered scan controller for a common-anode seven-segment display.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_segment_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  // state    | meaning
  // ST_BLANK | guard interval at slot start, all anodes and segments off
  // ST_DRIVE | anode scan_idx on, segments decoded from the display register
  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [DIGITS-1:0][3:0] disp_nib, disp_nib_next, pend_nib;
  logic [DIGITS-1:0]      disp_dp, disp_dp_next, pend_dp;
  logic [DIGITS-1:0]      lz_blank;
  logic                   pending_full, slot_end, frame_end, commit;
  logic [DIGITS-1:0]      an_n_next;
  logic [6:0]             seg_n_next;
  logic                   dp_n_next, frame_done_next;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_scan
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run         = run && (disp_nib_next[k] == 4'h0) && !disp_dp_next[k];
      lz_blank[k] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs are registered, so they are computed from next-cycle state and display contents.
  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    frame_end = slot_end && (idx == IDX_MAX);
    commit    = frame_end && pending_full;

    cnt_next = slot_end ? '0 : cnt + 1'b1;
    idx_next = idx;
    if (slot_end) idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;

    state_next = state;
    case (state)
      ST_BLANK: if (cnt_next >= CNT_BLANK) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_end && (CNT_BLANK != '0)) state_next = ST_BLANK;
      default:  state_next = ST_BLANK;
    endcase

    disp_nib_next = commit ? pend_nib : disp_nib;
    disp_dp_next  = commit ? pend_dp  : disp_dp;

    an_n_next  = '1;
    seg_n_next = '1;
    dp_n_next  = 1'b1;
    if (state_next == ST_DRIVE) begin
      an_n_next[idx_next] = 1'b0;
      dp_n_next           = !disp_dp_next[idx_next];
      if (!lz_blank[idx_next]) seg_n_next = decode(disp_nib_next[idx_next]);
    end
    frame_done_next = (idx_next == IDX_MAX) && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BLANK;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      disp_nib     <= '0;
      disp_dp      <= '0;
      pend_nib     <= '0;
      pend_dp      <= '0;
      pending_full <= 1'b0;
      an_n         <= '1;
      seg_n        <= '1;
      dp_n         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      disp_nib   <= disp_nib_next;
      disp_dp    <= disp_dp_next;
      an_n       <= an_n_next;
      seg_n      <= seg_n_next;
      dp_n       <= dp_n_next;
      frame_done <= frame_done_next;
      // A load offered on the commit cycle only lands in pending when it was empty.
      if (commit) begin
        pending_full <= 1'b0;
      end else if (load_valid && !pending_full) begin
        pend_nib     <= load_data;
        pend_dp      <= load_dp;
        pending_full <= 1'b1;
      end
    end
  end

  assign load_ready = !pending_full;
  assign scan_idx   = idx;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed, table-driven bench for seven_segment_scan_controller (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
module tb_seven_segment_scan_controller;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  seven_segment_scan_controller #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  typedef logic [3:0][6:0] segs_t;
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    int          pos;
    segs_t       seg;
    logic [3:0]  dpn;
  } vec_t;

  localparam logic [6:0] OFF = 7'b1111111;

  // Observed word: {an_n, seg_n, dp_n, frame_done, scan_idx, load_ready}
  function automatic logic [15:0] obs();
    return {an_n, seg_n, dp_n, frame_done, scan_idx, load_ready};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One 32-cycle frame; called with the DUT at the start of a frame (before its pos-0 sample).
  task automatic run_frame(input segs_t eseg, input logic [3:0] edpn, input logic [31:0] rmask,
                           input logic [31:0] vmask, input logic [15:0] da, input logic [3:0] pa,
                           input logic [15:0] db, input logic [3:0] pb, input int sw,
                           input int rst_pos);
    for (int pos = 0; pos < 32; pos++) begin
      int k, s;
      logic [3:0]  an_e;
      logic [6:0]  seg_e;
      logic        dp_e;
      logic [15:0] e;
      @(negedge clk);
      k = pos / PRESCALE;
      s = pos % PRESCALE;
      if (s < BLANK) begin
        an_e = 4'hF; seg_e = OFF; dp_e = 1'b1;
      end else begin
        an_e = ~(4'b0001 << k); seg_e = eseg[k]; dp_e = edpn[k];
      end
      e = {an_e, seg_e, dp_e, (pos == 31), 2'(k), rmask[pos]};
      check($sformatf("frame%0d_pos%0d", frame_no, pos), obs(), e);
      load_valid = vmask[pos];
      load_data  = (pos < sw) ? da : db;
      load_dp    = (pos < sw) ? pa : pb;
      if (pos == rst_pos) begin
        rst = 1'b1;
        break;
      end
    end
    frame_no++;
  endtask

  initial begin
    vec_t  vecs[6];
    segs_t prev_seg, zero_seg, x_seg, y_seg, z_seg;
    logic [3:0]  prev_dpn;
    logic [31:0] rm;

    zero_seg = {4{7'b1000000}};
    vecs[0] = '{data:16'h1234, dp:4'b0010, pos:0,
                seg:{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dpn:4'b1101};
    vecs[1] = '{data:16'hABCD, dp:4'b0000, pos:13,
                seg:{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, dpn:4'b1111};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    vecs[2] = '{data:16'h0007, dp:4'b0000, pos:5,
                seg:{OFF, OFF, OFF, 7'b1111000}, dpn:4'b1111};
    vecs[3] = '{data:16'h0000, dp:4'b0000, pos:20,
                seg:{OFF, OFF, OFF, 7'b1000000}, dpn:4'b1111};
    vecs[5] = '{data:16'h0680, dp:4'b0100, pos:2,
                seg:{OFF, 7'b0000010, 7'b0000000, 7'b1000000}, dpn:4'b1011};
    z_seg   = {OFF, 7'b0000011, 7'b0010010, 7'b1000000};
`else
    vecs[2] = '{data:16'h0007, dp:4'b0000, pos:5,
                seg:{7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, dpn:4'b1111};
    vecs[3] = '{data:16'h0000, dp:4'b0000, pos:20,
                seg:{4{7'b1000000}}, dpn:4'b1111};
    vecs[5] = '{data:16'h0680, dp:4'b0100, pos:2,
                seg:{7'b1000000, 7'b0000010, 7'b0000000, 7'b1000000}, dpn:4'b1011};
    z_seg   = {7'b1000000, 7'b0000011, 7'b0010010, 7'b1000000};
`endif
    vecs[4] = '{data:16'h5E9F, dp:4'b1001, pos:30,
                seg:{7'b0010010, 7'b0000110, 7'b0010000, 7'b0001110}, dpn:4'b0110};
    x_seg = {7'b0100100, 7'b0011001, 7'b0000010, 7'b0000000};  // 0x2468
    y_seg = {7'b0010000, 7'b1000110, 7'b0110000, 7'b1111001};  // 0x9C31

    // Outputs held at reset values while rst is asserted.
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", obs(), {4'hF, OFF, 1'b1, 1'b0, 2'd0, 1'b1});
    end
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(zero_seg, 4'hF, 32'hFFFF_FFFF, 32'h0, '0, '0, '0, '0, 32, -1);

    // Each vector is loaded during one frame and must show in the next.
    prev_seg = zero_seg;
    prev_dpn = 4'hF;
    for (int i = 0; i < 6; i++) begin
      rm = '0;
      for (int j = 0; j <= vecs[i].pos; j++) rm[j] = 1'b1;
      run_frame(prev_seg, prev_dpn, rm, 32'h1 << vecs[i].pos,
                vecs[i].data, vecs[i].dp, vecs[i].data, vecs[i].dp, 32, -1);
      prev_seg = vecs[i].seg;
      prev_dpn = vecs[i].dpn;
    end

    // Back-to-back: X accepted at pos 3, Y held valid and stalled until the next frame start.
    run_frame(prev_seg, prev_dpn, 32'h0000_000F, 32'hFFFF_FFF8,
              16'h2468, 4'b0001, 16'h9C31, 4'b1000, 4, -1);
    run_frame(x_seg, 4'b1110, 32'h0000_0001, 32'h0000_0001,
              16'h9C31, 4'b1000, 16'h9C31, 4'b1000, 32, -1);
    // Load on the frame_done cycle with pending empty: commits one frame later.
    run_frame(y_seg, 4'b0111, 32'hFFFF_FFFF, 32'h8000_0000,
              16'h0B50, 4'b0000, 16'h0B50, 4'b0000, 32, -1);
    run_frame(y_seg, 4'b0111, 32'h0000_0000, 32'h0, '0, '0, '0, '0, 32, -1);
    run_frame(z_seg, 4'hF, 32'hFFFF_FFFF, 32'h0, '0, '0, '0, '0, 32, -1);

    // Reset during DRIVE of digit 2 with pending full; pending must be discarded.
    run_frame(z_seg, 4'hF, 32'h0000_0003, 32'h0000_0002,
              16'h8888, 4'hF, 16'h8888, 4'hF, 32, 20);
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(zero_seg, 4'hF, 32'hFFFF_FFFF, 32'h0, '0, '0, '0, '0, 32, -1);
    run_frame(zero_seg, 4'hF, 32'hFFFF_FFFF, 32'h0, '0, '0, '0, '0, 32, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
